// File: rtl/fpu_issue_seq_pkg.sv
// Shared encodings for the FP issue sequencer: op codes, FSM states and
// exception flag bit positions.
package fpu_issue_seq_pkg;

    localparam logic [3:0] F_ALU_OP_ADD     = 4'd0;
    localparam logic [3:0] F_ALU_OP_SUB     = 4'd1;
    localparam logic [3:0] F_ALU_OP_MUL     = 4'd2;
    localparam logic [3:0] F_ALU_OP_MIN     = 4'd3;
    localparam logic [3:0] F_ALU_OP_MAX     = 4'd4;
    localparam logic [3:0] F_ALU_OP_EQ      = 4'd5;
    localparam logic [3:0] F_ALU_OP_LT      = 4'd6;
    localparam logic [3:0] F_ALU_OP_LE      = 4'd7;
    localparam logic [3:0] F_ALU_OP_ILLEGAL = 4'hF;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    // Only codes 0..7 are implemented; anything with the top bit set is illegal.
    function automatic logic op_is_legal(input logic [3:0] op);
        return ~op[3];
    endfunction

    function automatic logic op_is_cmp(input logic [3:0] op);
        return (op == F_ALU_OP_EQ) || (op == F_ALU_OP_LT) || (op == F_ALU_OP_LE);
    endfunction

endpackage

// File: rtl/fpu_issue_seq_timeout_ctr.sv
// Timeout counter for the WAIT state: cleared on issue, counts while waiting,
// flags the cycle in which the count reaches TIMEOUT_CYC.
module fpu_timeout_ctr #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // The count before the final increment; tc marks the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = en && (count_reg == LAST_VAL);

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue sequencer between decode and a multi-cycle FP core: launches one op,
// stalls until done or timeout, writes back and accumulates sticky flags.
module fpu_issue_seq
    import fpu_issue_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fp_start_i,
    input  logic [3:0]      fpu_op_i,
    input  logic            fp_reg_write_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    output logic            fpu_start_o,
    output logic [3:0]      fpu_op_o,
    output logic [XLEN-1:0] fpu_a_o,
    output logic [XLEN-1:0] fpu_b_o,
    input  logic            fpu_done_i,
    input  logic [XLEN-1:0] fpu_result_i,
    input  logic [4:0]      fpu_flags_i,
    output logic            stall_o,
    output logic            fp_we_o,
    output logic            int_we_o,
    output logic [4:0]      wb_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      fflags_o,
    input  logic            fflags_clr_i,
    output logic            illegal_o,
    output logic            timeout_o
);

    state_t            state_reg;
    logic [3:0]        op_reg;
    logic [XLEN-1:0]   a_reg;
    logic [XLEN-1:0]   b_reg;
    logic [4:0]        rd_reg;
    logic              fp_reg_write_reg;
    logic              is_cmp_reg;
    logic              start_reg;
    logic              illegal_reg;
    logic              timeout_reg;
    logic              fp_we_reg;
    logic              int_we_reg;
    logic [4:0]        wb_addr_reg;
    logic [XLEN-1:0]   wb_data_reg;
    logic [FLAG_W-1:0] pend_flags_reg;
    logic [FLAG_W-1:0] fflags_reg;

    logic              accept;
    logic              tc;
    logic              launch;
    logic [XLEN-1:0]   wb_data_next;

    assign launch       = (state_reg == S_IDLE) && fp_start_i && op_is_legal(fpu_op_i);
    assign accept       = fpu_done_i && ((state_reg == S_ISSUE) || (state_reg == S_WAIT));
    assign wb_data_next = is_cmp_reg ? {{(XLEN-1){1'b0}}, fpu_result_i[0]} : fpu_result_i;

    fpu_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (state_reg == S_ISSUE),
        .en  (state_reg == S_WAIT),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            op_reg           <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            rd_reg           <= '0;
            fp_reg_write_reg <= 1'b0;
            is_cmp_reg       <= 1'b0;
            start_reg        <= 1'b0;
            illegal_reg      <= 1'b0;
            timeout_reg      <= 1'b0;
            fp_we_reg        <= 1'b0;
            int_we_reg       <= 1'b0;
            wb_addr_reg      <= '0;
            wb_data_reg      <= '0;
            pend_flags_reg   <= '0;
            fflags_reg       <= '0;
        end else begin
            start_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
            fp_we_reg   <= 1'b0;
            int_we_reg  <= 1'b0;
            if (fflags_clr_i) begin
                fflags_reg <= '0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (launch) begin
                        op_reg           <= fpu_op_i;
                        a_reg            <= rs1_val_i;
                        b_reg            <= rs2_val_i;
                        rd_reg           <= rd_i;
                        fp_reg_write_reg <= fp_reg_write_i;
                        is_cmp_reg       <= op_is_cmp(fpu_op_i);
                        start_reg        <= 1'b1;
                        state_reg        <= S_ISSUE;
                    end else if (fp_start_i) begin
                        illegal_reg <= 1'b1;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    // A done pulse beats a simultaneous timeout.
                    if (accept) begin
                        wb_addr_reg    <= rd_reg;
                        wb_data_reg    <= wb_data_next;
                        pend_flags_reg <= fpu_flags_i;
                        fp_we_reg      <= fp_reg_write_reg && !is_cmp_reg;
                        int_we_reg     <= is_cmp_reg;
                        state_reg      <= S_WB;
                    end else if (state_reg == S_ISSUE) begin
                        state_reg <= S_WAIT;
                    end else if (tc) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= S_IDLE;
                    end
                end
                S_WB: begin
                    fflags_reg <= (fflags_clr_i ? '0 : fflags_reg) | pend_flags_reg;
                    state_reg  <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Stall rises in the same cycle decode presents a legal op.
    assign stall_o     = !rst && (launch || (state_reg == S_ISSUE) || (state_reg == S_WAIT));
    assign fpu_start_o = start_reg;
    assign fpu_op_o    = op_reg;
    assign fpu_a_o     = a_reg;
    assign fpu_b_o     = b_reg;
    assign fp_we_o     = fp_we_reg;
    assign int_we_o    = int_we_reg;
    assign wb_addr_o   = wb_addr_reg;
    assign wb_data_o   = wb_data_reg;
    assign fflags_o    = fflags_reg;
    assign illegal_o   = illegal_reg;
    assign timeout_o   = timeout_reg;

endmodule
